episode_sched: RTL
==================

EPISODE_SCHED -- requirements
Module: episode_sched

Interface
REQ-001 Parameter EP_W, default 12, episode counter and total width.
REQ-002 Parameter ST_W, default 4, step counter and step-limit width.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 resets the block.
REQ-005 start  input  1  run request, sampled only in IDLE or DONE.
REQ-006 total_episode_in  input  EP_W  number of episodes to run, latched on accepted start.
REQ-007 max_step_in  input  ST_W  step limit per episode, latched on accepted start; 0 means 2^ST_W.
REQ-008 dp_ack  input  1  datapath finished current Q-update step.
REQ-009 goal_reached  input  1  next state is terminal; valid only together with dp_ack.
REQ-010 dp_req  output  1  request the datapath to run one Q-update step.
REQ-011 phase  output  3  current state code.
REQ-012 step  output  ST_W  step index within the current episode.
REQ-013 episode  output  EP_W  current episode index.
REQ-014 new_episode  output  1  one-cycle pulse at the start of each episode.
REQ-015 busy  output  1  high in INIT, STEP and EVAL.
REQ-016 done  output  1  level, high in DONE.
REQ-017 err  output  1  sticky acknowledge-timeout flag.

Function
REQ-018 All outputs are registered or decoded from the state register only; no input-to-output combinational paths exist.
REQ-019 States: IDLE=0, INIT=1, STEP=2, EVAL=3, DONE=4; codes 5-7 are unreachable and return to IDLE on the next edge.
REQ-020 IDLE, start=1, total_episode_in!=0: latch totals, episode=0, go INIT.
REQ-021 IDLE or DONE, start=1, total_episode_in=0: go DONE (from IDLE) or stay in DONE; no dp_req is issued.
REQ-022 INIT: step=0, new_episode=1 for this cycle only, go STEP next edge.
REQ-023 STEP: dp_req=1; held until dp_ack=1 is sampled, then go EVAL; goal_reached is registered at that same edge.
REQ-024 dp_ack outside STEP is ignored.
REQ-025 EVAL, episode end (registered goal=1, or step=limit-1): if episode=total-1 go DONE; else episode+1, go INIT.
REQ-026 EVAL, not episode end: step+1, go STEP.
REQ-027 Latency: start sampled at edge k puts dp_req high from edge k+1; dp_ack at edge m puts dp_req low for exactly one cycle, then high again from edge m+1 if stepping continues.
REQ-028 With max_step_in=0, the step limit is 2^ST_W and step runs 0..2^ST_W-1 without wrapping.
REQ-029 DONE: done=1, busy=0, step and episode hold their last values; start=1 with total!=0 re-latches the inputs, clears episode, and goes INIT.
REQ-030 start asserted while busy=1 is ignored, and the latched totals do not change.
REQ-031 Counter arithmetic is unsigned, with no wrap of episode beyond total-1.

Reset
REQ-032 rst=0 asynchronously forces: state=IDLE, dp_req=0, step=0, episode=0, new_episode=0, busy=0, done=0, err=0, latched totals=0.
REQ-033 Reset mid-run aborts immediately; there is no resume; a new start is required after rst returns to 1.

Configuration
REQ-034 Macro ACK_WATCHDOG_EN defined: an 8-bit counter clears on STEP entry and counts each STEP cycle without dp_ack; on reaching 255 it sets err=1 (sticky until reset or an accepted start) and the block goes DONE.
REQ-035 Macro ACK_WATCHDOG_EN undefined: err is tied 0, and STEP waits for dp_ack indefinitely.

Verification
REQ-036 total=3, max_step=4, dp_ack 2 cycles after each dp_req, goal=0 -> 12 dp_req pulses, new_episode pulses at episodes 0,1,2, then done=1 with episode=2, step=3.
REQ-037 total=2, max_step=8, goal_reached=1 with the 3rd dp_ack of each episode -> episodes end at step=2, 6 steps in total, done=1.
REQ-038 total=1, max_step=0, immediate dp_ack -> 16 steps (step 0..15), then done=1, step=15.
REQ-039 total=0, start=1 -> DONE on the next edge, dp_req never high; start during busy has no effect; rst=0 mid-STEP -> all outputs zero at once.
REQ-040 With ACK_WATCHDOG_EN defined, dp_ack withheld -> err=1 and DONE 255 cycles after STEP entry; without the macro, err stays 0 and dp_req stays high.

Source files
------------

// File: rtl/episode_sched.sv
// episode_sched: episode/step sequencer driving a Q-update datapath.
// Optional ACK_WATCHDOG_EN adds a STEP acknowledge timeout with sticky err.
module episode_sched #(
   parameter int EP_W = 12,
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [EP_W-1:0] total_episode_in,
   input  logic [ST_W-1:0] max_step_in,
   input  logic            dp_ack,
   input  logic            goal_reached,
   output logic            dp_req,
   output logic [2:0]      phase,
   output logic [ST_W-1:0] step,
   output logic [EP_W-1:0] episode,
   output logic            new_episode,
   output logic            busy,
   output logic            done,
   output logic            err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_STEP = 3'd2,
      S_EVAL = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [EP_W-1:0] r_total;
   logic [ST_W-1:0] r_max;
   logic [ST_W-1:0] r_step;
   logic [EP_W-1:0] r_episode;
   logic            r_goal;

   logic            w_start_ok;
   logic            w_go;
   logic [ST_W-1:0] w_last_step;
   logic            w_ep_end;
   logic            w_last_ep;
   logic            w_wd_trip;
   logic            w_enter_step;

   // max_step_in of 0 wraps to all-ones here, i.e. a 2^ST_W step limit
   assign w_last_step  = r_max - ST_W'(1);
   assign w_ep_end     = r_goal || (r_step == w_last_step);
   assign w_last_ep    = (r_episode == (r_total - EP_W'(1)));
   assign w_start_ok   = start && ((r_state == S_IDLE) ||
                                   (r_state == S_DONE));
   assign w_go         = w_start_ok && (total_episode_in != '0);
   assign w_enter_step = (w_next == S_STEP) && (r_state != S_STEP);

`ifdef ACK_WATCHDOG_EN
   logic [7:0] r_wdog;
   logic       r_err;

   assign w_wd_trip = (r_state == S_STEP) && !dp_ack &&
                      (r_wdog == 8'd254);
   assign err       = r_err;

   // acknowledge timeout counter and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_enter_step)
            r_wdog <= '0;
         else if ((r_state == S_STEP) && !dp_ack)
            r_wdog <= r_wdog + 8'd1;
         if (w_start_ok)
            r_err <= 1'b0;
         else if (w_wd_trip)
            r_err <= 1'b1;
      end
   end
`else
   assign w_wd_trip = 1'b0;
   assign err       = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // next-state decode; unused codes fall back to IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_next = w_go ? S_INIT : S_DONE;
         end
         S_INIT: w_next = S_STEP;
         S_STEP: begin
            if (dp_ack)         w_next = S_EVAL;
            else if (w_wd_trip) w_next = S_DONE;
         end
         S_EVAL: begin
            if (!w_ep_end)      w_next = S_STEP;
            else if (w_last_ep) w_next = S_DONE;
            else                w_next = S_INIT;
         end
         S_DONE: begin
            if (w_go) w_next = S_INIT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // latched run parameters and episode/step counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_total   <= '0;
         r_max     <= '0;
         r_step    <= '0;
         r_episode <= '0;
         r_goal    <= 1'b0;
      end else begin
         if (w_go) begin
            r_total   <= total_episode_in;
            r_max     <= max_step_in;
            r_episode <= '0;
         end
         if (w_next == S_INIT)
            r_step <= '0;
         else if ((r_state == S_EVAL) && (w_next == S_STEP))
            r_step <= r_step + ST_W'(1);
         if ((r_state == S_EVAL) && (w_next == S_INIT))
            r_episode <= r_episode + EP_W'(1);
         if ((r_state == S_STEP) && dp_ack)
            r_goal <= goal_reached;
      end
   end

   assign phase       = r_state;
   assign dp_req      = (r_state == S_STEP);
   assign new_episode = (r_state == S_INIT);
   assign busy        = (r_state == S_INIT) || (r_state == S_STEP) ||
                        (r_state == S_EVAL);
   assign done        = (r_state == S_DONE);
   assign step        = r_step;
   assign episode     = r_episode;

endmodule
